pe_network_interface: RTL and testbench

//  Per-node network interface between a processing element (PE) and the PE port of one router in the 4x4 mesh.

---
 rtl/pe_network_interface.sv | 152 +++++++++++++++
 tb/tb_pe_network_interface.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_network_interface.sv
// rtl/pe_network_interface.sv - PE-to-router network interface: packet build, injection and ejection buffering
// Injection FIFO feeds a one-entry output register toward the router; ejection FIFO buffers packets for the PE.
module pe_network_interface #(
  parameter int NODE_X    = 0,
  parameter int NODE_Y    = 0,
  parameter int INJ_DEPTH = 4,
  parameter int EJ_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inj_valid,
  output logic        inj_ready,
  input  logic [1:0]  inj_dst_x,
  input  logic [1:0]  inj_dst_y,
  input  logic [31:0] inj_payload,
  output logic        si_PE,
  input  logic        ri_PE,
  output logic [63:0] PE_in_packet,
  input  logic        polarity,
  input  logic        so_PE,
  output logic        ro_PE,
  input  logic [63:0] PE_out_packet,
  output logic        ej_valid,
  input  logic        ej_ready,
  output logic [3:0]  ej_src,
  output logic [7:0]  ej_seq,
  output logic [31:0] ej_payload,
  output logic        err_misroute,
  output logic [15:0] inj_count,
  output logic [15:0] ej_count
);

  localparam int IAW = $clog2(INJ_DEPTH);
  localparam int EAW = $clog2(EJ_DEPTH);
  localparam logic [1:0] NX = 2'(NODE_X);
  localparam logic [1:0] NY = 2'(NODE_Y);
  localparam logic [3:0] NODE_ID = {NY, NX};

  // ---------------- injection FIFO ----------------
  logic [35:0]  inj_mem [INJ_DEPTH];
  logic [IAW:0] inj_wr, inj_rd, inj_cnt;
  logic         inj_full, inj_empty, inj_push;

  assign inj_cnt   = inj_wr - inj_rd;
  assign inj_full  = inj_cnt[IAW];
  assign inj_empty = (inj_wr == inj_rd);
  assign inj_ready = !inj_full;
  assign inj_push  = inj_valid && !inj_full;

  always_ff @(posedge clk) begin
    if (inj_push) inj_mem[inj_wr[IAW-1:0]] <= {inj_dst_y, inj_dst_x, inj_payload};
  end

  logic [1:0]  hd_x, hd_y, adx, ady;
  logic [31:0] hd_pay;
  logic        dir_x, dir_y;
  logic [7:0]  seq_q;
  logic        vc_q;
  logic [63:0] next_pkt;

  assign {hd_y, hd_x, hd_pay} = inj_mem[inj_rd[IAW-1:0]];

  // Direction bits are zero when the delta is zero, so "greater than" selects +x / +y.
  always_comb begin
    dir_x    = hd_x > NX;
    dir_y    = hd_y > NY;
    adx      = dir_x ? (hd_x - NX) : (NX - hd_x);
    ady      = dir_y ? (hd_y - NY) : (NY - hd_y);
    next_pkt = {vc_q, dir_x, dir_y, 5'b0, 2'b00, adx, 2'b00, ady,
                NODE_ID, hd_y, hd_x, seq_q, hd_pay};
  end

  // ---------------- output register toward the router ----------------
  logic        out_valid;
  logic [63:0] out_pkt;
  logic        xfer, load;

  assign si_PE        = out_valid && (polarity == out_pkt[63]);
  assign xfer         = si_PE && ri_PE;
  assign load         = !inj_empty && (!out_valid || xfer);
  assign PE_in_packet = out_pkt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inj_wr    <= '0;
      inj_rd    <= '0;
      out_valid <= 1'b0;
      out_pkt   <= '0;
      seq_q     <= '0;
      vc_q      <= 1'b0;
      inj_count <= '0;
    end else begin
      if (inj_push) inj_wr <= inj_wr + 1'b1;
      if (load) begin
        inj_rd    <= inj_rd + 1'b1;
        out_pkt   <= next_pkt;
        out_valid <= 1'b1;
        seq_q     <= seq_q + 8'd1;
        vc_q      <= ~vc_q;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
      if (xfer) inj_count <= inj_count + 16'd1;
    end
  end

  // ---------------- ejection FIFO ----------------
  logic [43:0]  ej_mem [EJ_DEPTH];
  logic [EAW:0] ej_wr, ej_rd, ej_cnt;
  logic         ej_full, ej_empty, cap, dst_ok, ej_push, ej_pop;
  logic [15:0]  unused_hdr;

  assign unused_hdr = PE_out_packet[63:48];
  assign ej_cnt     = ej_wr - ej_rd;
  assign ej_full    = ej_cnt[EAW];
  assign ej_empty   = (ej_wr == ej_rd);
  assign ro_PE      = !ej_full;
  assign cap        = so_PE && ro_PE;
  assign dst_ok     = (PE_out_packet[43:40] == NODE_ID);
  assign ej_push    = cap && dst_ok;
  assign ej_valid   = !ej_empty;
  assign ej_pop     = ej_valid && ej_ready;

  always_ff @(posedge clk) begin
    if (ej_push) ej_mem[ej_wr[EAW-1:0]] <= {PE_out_packet[47:44], PE_out_packet[39:0]};
  end

  // Head fields are masked while empty so the outputs read zero out of reset.
  always_comb begin
    ej_src     = '0;
    ej_seq     = '0;
    ej_payload = '0;
    if (ej_valid) {ej_src, ej_seq, ej_payload} = ej_mem[ej_rd[EAW-1:0]];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ej_wr        <= '0;
      ej_rd        <= '0;
      err_misroute <= 1'b0;
      ej_count     <= '0;
    end else begin
      if (ej_push) ej_wr <= ej_wr + 1'b1;
      if (ej_pop) begin
        ej_rd    <= ej_rd + 1'b1;
        ej_count <= ej_count + 16'd1;
      end
      err_misroute <= cap && !dst_ok;
    end
  end

endmodule

// File: tb/tb_pe_network_interface.sv
// tb/tb_pe_network_interface.sv - directed self-checking bench for pe_network_interface at node (1,1)
module tb_pe_network_interface;

  logic        clk = 1'b0;
  logic        reset;
  logic        inj_valid, inj_ready;
  logic [1:0]  inj_dst_x, inj_dst_y;
  logic [31:0] inj_payload;
  logic        si_PE, ri_PE, polarity;
  logic [63:0] PE_in_packet;
  logic        so_PE, ro_PE;
  logic [63:0] PE_out_packet;
  logic        ej_valid, ej_ready;
  logic [3:0]  ej_src;
  logic [7:0]  ej_seq;
  logic [31:0] ej_payload;
  logic        err_misroute;
  logic [15:0] inj_count, ej_count;

  int checks = 0;
  int failures = 0;

  pe_network_interface #(.NODE_X(1), .NODE_Y(1), .INJ_DEPTH(4), .EJ_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .inj_valid(inj_valid), .inj_ready(inj_ready), .inj_dst_x(inj_dst_x), .inj_dst_y(inj_dst_y),
    .inj_payload(inj_payload), .si_PE(si_PE), .ri_PE(ri_PE), .PE_in_packet(PE_in_packet),
    .polarity(polarity), .so_PE(so_PE), .ro_PE(ro_PE), .PE_out_packet(PE_out_packet),
    .ej_valid(ej_valid), .ej_ready(ej_ready), .ej_src(ej_src), .ej_seq(ej_seq),
    .ej_payload(ej_payload), .err_misroute(err_misroute), .inj_count(inj_count), .ej_count(ej_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  dx;
    logic [1:0]  dy;
    logic [31:0] pay;
    logic [63:0] pkt;
  } inj_vec_t;

  inj_vec_t vec [4];
  logic [31:0] ej_pays [4];
  logic [63:0] drained [5];
  logic [7:0]  exp_vc [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mk_ej(input logic [3:0] src, input logic [3:0] dst,
                                        input logic [7:0] seq, input logic [31:0] pay);
    return {16'h0, src, dst, seq, pay};
  endfunction

  task automatic deliver(input logic [63:0] p);
    so_PE = 1'b1;
    PE_out_packet = p;
    step();
    so_PE = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_inj_ready"}, 64'(inj_ready), 64'd1);
    check({tag, "_si_PE"}, 64'(si_PE), 64'd0);
    check({tag, "_PE_in_packet"}, PE_in_packet, 64'd0);
    check({tag, "_ro_PE"}, 64'(ro_PE), 64'd1);
    check({tag, "_ej_valid"}, 64'(ej_valid), 64'd0);
    check({tag, "_ej_fields"}, 64'({ej_src, ej_seq, ej_payload}), 64'd0);
    check({tag, "_err"}, 64'(err_misroute), 64'd0);
    check({tag, "_counts"}, 64'({inj_count, ej_count}), 64'd0);
  endtask

  initial begin
    int accepted;
    int got;
    // node (1,1) = id 5; packets hand-built from the field layout
    vec[0] = '{2'd3, 2'd0, 32'hCAFE_0001, 64'h4021_5300_CAFE_0001};
    vec[1] = '{2'd1, 2'd1, 32'h0000_0055, 64'h8000_5501_0000_0055};
    vec[2] = '{2'd0, 2'd3, 32'hDEAD_BEEF, 64'h2012_5C02_DEAD_BEEF};
    vec[3] = '{2'd2, 2'd2, 32'h0000_0001, 64'hE011_5A03_0000_0001};
    ej_pays[0] = 32'hA000_0001; ej_pays[1] = 32'hA000_0002;
    ej_pays[2] = 32'hA000_0003; ej_pays[3] = 32'hA000_0004;
    exp_vc[0] = 8'd0; exp_vc[1] = 8'd1; exp_vc[2] = 8'd0; exp_vc[3] = 8'd1; exp_vc[4] = 8'd0;

    reset = 1'b0;
    inj_valid = 1'b0; inj_dst_x = '0; inj_dst_y = '0; inj_payload = '0;
    ri_PE = 1'b1; polarity = 1'b0; so_PE = 1'b0; PE_out_packet = '0; ej_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b1;
    step();

    // table-driven injections, one at a time
    for (int i = 0; i < 4; i++) begin
      inj_valid = 1'b1; inj_dst_x = vec[i].dx; inj_dst_y = vec[i].dy; inj_payload = vec[i].pay;
      polarity = ~vec[i].pkt[63];
      step();
      inj_valid = 1'b0;
      step();
      check($sformatf("inj%0d_packet", i), PE_in_packet, vec[i].pkt);
      check($sformatf("inj%0d_si_wrong_pol", i), 64'(si_PE), 64'd0);
      polarity = vec[i].pkt[63];
      #1;
      check($sformatf("inj%0d_si_match_pol", i), 64'(si_PE), 64'd1);
      step();
      check($sformatf("inj%0d_count", i), 64'(inj_count), 64'(i + 1));
      check($sformatf("inj%0d_si_after", i), 64'(si_PE), 64'd0);
    end

    // fill with router stalled: 4 in FIFO plus 1 in output register
    ri_PE = 1'b0;
    inj_dst_x = 2'd1; inj_dst_y = 2'd1;
    accepted = 0;
    for (int k = 0; k < 10; k++) begin
      inj_valid = 1'b1;
      inj_payload = 32'hF000_0000 + 32'(accepted);
      #1;
      if (!inj_ready) break;
      step();
      accepted++;
    end
    inj_valid = 1'b0;
    check("fill_accepted", 64'(accepted), 64'd5);
    check("fill_inj_ready", 64'(inj_ready), 64'd0);

    ri_PE = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      polarity = ~polarity;
      #1;
      if (si_PE) begin
        drained[got] = PE_in_packet;
        got++;
      end
      step();
    end
    check("drain_count", 64'(got), 64'd5);
    for (int j = 0; j < 5; j++) begin
      check($sformatf("drain%0d_payload", j), 64'(drained[j][31:0]), 64'(32'hF000_0000 + 32'(j)));
      check($sformatf("drain%0d_vc", j), 64'(drained[j][63]), 64'(exp_vc[j]));
      check($sformatf("drain%0d_seq", j), 64'(drained[j][39:32]), 64'(4 + j));
    end
    check("drain_inj_count", 64'(inj_count), 64'd9);
    check("drain_inj_ready", 64'(inj_ready), 64'd1);

    // ejection of a correctly addressed packet
    deliver(mk_ej(4'd9, 4'd5, 8'h07, 32'h1234_5678));
    check("ej_valid", 64'(ej_valid), 64'd1);
    check("ej_src", 64'(ej_src), 64'd9);
    check("ej_seq", 64'(ej_seq), 64'h07);
    check("ej_payload", 64'(ej_payload), 64'h1234_5678);
    check("ej_no_err", 64'(err_misroute), 64'd0);
    ej_ready = 1'b1;
    step();
    ej_ready = 1'b0;
    check("ej_count_1", 64'(ej_count), 64'd1);
    check("ej_valid_after_pop", 64'(ej_valid), 64'd0);

    // misrouted packet
    deliver(mk_ej(4'd2, 4'd6, 8'h01, 32'h5555_AAAA));
    check("misroute_pulse", 64'(err_misroute), 64'd1);
    check("misroute_ej_valid", 64'(ej_valid), 64'd0);
    step();
    check("misroute_pulse_end", 64'(err_misroute), 64'd0);
    check("misroute_ej_count", 64'(ej_count), 64'd1);

    // ejection FIFO full, fifth delivery ignored
    for (int j = 0; j < 4; j++) deliver(mk_ej(4'd3, 4'd5, 8'(j), ej_pays[j]));
    check("ej_full_ro_PE", 64'(ro_PE), 64'd0);
    deliver(mk_ej(4'd3, 4'd5, 8'hFF, 32'h0000_0BAD));
    for (int j = 0; j < 4; j++) begin
      check($sformatf("ej_order%0d_valid", j), 64'(ej_valid), 64'd1);
      check($sformatf("ej_order%0d_payload", j), 64'(ej_payload), 64'(ej_pays[j]));
      ej_ready = 1'b1;
      step();
      ej_ready = 1'b0;
      if (j == 0) check("ej_ro_PE_after_pop", 64'(ro_PE), 64'd1);
    end
    check("ej_drained_empty", 64'(ej_valid), 64'd0);
    check("ej_count_5", 64'(ej_count), 64'd5);

    // asynchronous reset with packets in flight
    ri_PE = 1'b0;
    inj_valid = 1'b1; inj_dst_x = 2'd2; inj_dst_y = 2'd0; inj_payload = 32'h1111_0000;
    repeat (3) step();
    inj_valid = 1'b0;
    deliver(mk_ej(4'd1, 4'd5, 8'h33, 32'h2222_0000));
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    reset = 1'b1;
    step();
    ri_PE = 1'b1; polarity = 1'b0;
    inj_valid = 1'b1; inj_dst_x = 2'd1; inj_dst_y = 2'd1; inj_payload = 32'h0000_0077;
    step();
    inj_valid = 1'b0;
    step();
    check("post_rst_packet", PE_in_packet, 64'h0000_5500_0000_0077);
    check("post_rst_si", 64'(si_PE), 64'd1);
    step();
    check("post_rst_inj_count", 64'(inj_count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
